// File: rtl/tempsens_pkg.sv
// Shared types and constants for the ring-oscillator temperature sensor sequencer.
package tempsens_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned RESULT_W = 16;

    localparam logic [BYTE_W-1:0] CMD_START  = 8'h53;
    localparam logic [BYTE_W-1:0] CMD_RESEND = 8'h52;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        ACCUM,
        SEND_LO,
        WAIT_LO,
        SEND_HI,
        WAIT_HI
    } state_t;

    // Selects the low or high byte of a result word for the UART.
    function automatic logic [BYTE_W-1:0] pick_byte(input logic [RESULT_W-1:0] word,
                                                    input logic                hi);
        return hi ? word[RESULT_W-1:BYTE_W] : word[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/tempsens_timer.sv
// Loadable down-counter; done is high while the count has reached zero.
module tempsens_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         count,
    output logic         done
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = value;
        end else if (count && (cnt != '0)) begin
            cnt_nxt = cnt - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            done <= 1'b1;
        end else begin
            cnt  <= cnt_nxt;
            done <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/tempsens_sequencer.sv
// Ring-oscillator measurement sequencer: gates the oscillator, averages samples, sends result over UART.
// Define TEMPSENS_AUTO_EN to add periodic auto-start after PERIOD_CYCLES idle cycles.
module tempsens_sequencer
    import tempsens_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned AVG_LOG2      = 4,
`ifdef TEMPSENS_AUTO_EN
    parameter int unsigned PERIOD_CYCLES = 100000,
`endif
    parameter int unsigned CNT_W         = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_ready,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic [CNT_W-1:0]    count,
    input  logic                tx_busy,
    output logic                osc_en,
    output logic                cnt_clr,
    output logic                tx_start,
    output logic [BYTE_W-1:0]   tx_data,
    output logic                busy,
    output logic [RESULT_W-1:0] result,
    output logic                result_valid
);

    localparam int unsigned ACC_W    = CNT_W + AVG_LOG2;
    localparam int unsigned IDX_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned LAST_IDX = (1 << AVG_LOG2) - 1;
    localparam int unsigned WIN_W    = $clog2(WINDOW_CYCLES + 2);

    state_t               state;
    state_t               state_nxt;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_nxt;
    logic [ACC_W-1:0]     acc_add;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [RESULT_W-1:0]  result_nxt;
    logic                 result_valid_nxt;
    logic [BYTE_W-1:0]    tx_data_nxt;
    logic                 tx_start_nxt;
    logic                 osc_en_nxt;
    logic                 cnt_clr_nxt;
    logic                 busy_nxt;
    logic [RESULT_W-1:0]  tx_word;

    logic                 win_load;
    logic [WIN_W-1:0]     win_value;
    logic                 win_count;
    logic                 win_done;
    logic                 auto_start;

    // One timer serves both the gate window and the two-cycle settle period.
    assign win_load  = (state == CLEAR) || ((state == GATE) && win_done);
    assign win_value = (state == CLEAR) ? WIN_W'(WINDOW_CYCLES - 1) : WIN_W'(1);
    assign win_count = (state == GATE) || (state == SETTLE);

    tempsens_timer #(
        .W (WIN_W)
    ) u_win_timer (
        .clk   (clk),
        .reset (reset),
        .load  (win_load),
        .value (win_value),
        .count (win_count),
        .done  (win_done)
    );

`ifdef TEMPSENS_AUTO_EN
    localparam int unsigned PER_W = $clog2(PERIOD_CYCLES + 1);

    logic per_armed;
    logic per_load;
    logic per_done;

    // Reloaded throughout every non-idle cycle, so the idle count restarts on each IDLE entry.
    assign per_load   = (state != IDLE) || !per_armed;
    assign auto_start = (state == IDLE) && per_armed && per_done;

    tempsens_timer #(
        .W (PER_W)
    ) u_period_timer (
        .clk   (clk),
        .reset (reset),
        .load  (per_load),
        .value (PER_W'(PERIOD_CYCLES - 1)),
        .count (state == IDLE),
        .done  (per_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_armed <= 1'b0;
        end else begin
            per_armed <= 1'b1;
        end
    end
`else
    assign auto_start = 1'b0;
`endif

    assign acc_add = acc + ACC_W'(count);
    assign tx_word = result_valid ? result : '0;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt        = state;
        acc_nxt          = acc;
        idx_nxt          = idx;
        result_nxt       = result;
        result_valid_nxt = result_valid;
        tx_data_nxt      = tx_data;
        tx_start_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if ((rx_ready && (rx_data == CMD_START)) || auto_start) begin
                    acc_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = CLEAR;
                end else if (rx_ready && (rx_data == CMD_RESEND)) begin
                    state_nxt = SEND_LO;
                end
            end
            CLEAR: begin
                state_nxt = GATE;
            end
            GATE: begin
                if (win_done) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (win_done) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                acc_nxt = acc_add;
                if (idx == IDX_W'(LAST_IDX)) begin
                    result_nxt       = RESULT_W'(acc_add >> AVG_LOG2);
                    result_valid_nxt = 1'b1;
                    state_nxt        = SEND_LO;
                end else begin
                    idx_nxt   = idx + IDX_W'(1);
                    state_nxt = CLEAR;
                end
            end
            SEND_LO: begin
                if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = pick_byte(tx_word, 1'b0);
                    state_nxt    = WAIT_LO;
                end
            end
            // tx_start is high only in the first wait cycle, which masks a late-rising tx_busy.
            WAIT_LO: begin
                if (!tx_start && !tx_busy) begin
                    state_nxt = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = pick_byte(tx_word, 1'b1);
                    state_nxt    = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (!tx_start && !tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        osc_en_nxt  = (state_nxt == GATE);
        cnt_clr_nxt = (state_nxt == CLEAR);
        busy_nxt    = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            osc_en       <= 1'b0;
            cnt_clr      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            acc          <= acc_nxt;
            idx          <= idx_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            tx_data      <= tx_data_nxt;
            tx_start     <= tx_start_nxt;
            osc_en       <= osc_en_nxt;
            cnt_clr      <= cnt_clr_nxt;
            busy         <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_tempsens_sequencer.sv
// Directed bench for tempsens_sequencer (WINDOW_CYCLES=8, AVG_LOG2=2) with a simple UART busy model.
module tb_tempsens_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic [15:0] count;
    logic        tx_busy;
    logic        osc_en;
    logic        cnt_clr;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [15:0] result;
    logic        result_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] samp [4];
    logic [2:0]  clr_idx = 3'd0;
    int          busy_cnt = 0;

    typedef struct packed {
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] s3;
        logic [15:0] res;
    } vec_t;

    vec_t vecs [5];

    tempsens_sequencer #(
        .WINDOW_CYCLES (8),
        .AVG_LOG2      (2),
        .CNT_W         (16)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .count        (count),
        .tx_busy      (tx_busy),
        .osc_en       (osc_en),
        .cnt_clr      (cnt_clr),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // UART: busy for 10 cycles after each send strobe.
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Ring counter: each clear advances to the next sample of the current table row.
    always @(posedge clk) begin
        if (!rst_n || (rx_ready && (rx_data == 8'h53))) clr_idx <= 3'd0;
        else if (cnt_clr) clr_idx <= clr_idx + 3'd1;
    end
    assign count = samp[2'(clr_idx - 3'd1)];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    // Issues a command and watches the run until both bytes are sent and the sequencer is idle.
    task automatic run_cmd(input logic [7:0] cmd, input int inject,
                           output int lat, output int ntx, output int win,
                           output int bad, output int excl,
                           output logic [7:0] b0, output logic [7:0] b1);
        int   n;
        int   run;
        logic prev_clr;
        lat = 0; ntx = 0; win = 0; bad = 0; excl = 0; b0 = 8'h00; b1 = 8'h00;
        n = 0; run = 0;
        send_byte(cmd);
        prev_clr = cnt_clr;
        while (n < 1000 && !(ntx == 2 && !busy)) begin
            @(posedge clk);
            #1;
            n++;
            rx_ready = 1'b0;
            if (inject != 0 && n == inject) begin
                rx_data  = 8'h53;
                rx_ready = 1'b1;
            end
            if (osc_en) begin
                if (run == 0 && !prev_clr) bad++;
                run++;
            end else if (run != 0) begin
                if (run != 8) bad++;
                win++;
                run = 0;
            end
            if (tx_start) begin
                if (ntx == 0) begin
                    lat = n;
                    b0  = tx_data;
                end else begin
                    b1 = tx_data;
                end
                ntx++;
            end
            if (int'(osc_en) + int'(cnt_clr) + int'(tx_start) > 1) excl++;
            prev_clr = cnt_clr;
        end
    endtask

    task automatic load_vec(input vec_t v);
        samp[0] = v.s0;
        samp[1] = v.s1;
        samp[2] = v.s2;
        samp[3] = v.s3;
    endtask

    task automatic measure_and_check(input string tag, input vec_t v, input int inject);
        int lat, ntx, win, bad, excl;
        logic [7:0] b0, b1;
        load_vec(v);
        run_cmd(8'h53, inject, lat, ntx, win, bad, excl, b0, b1);
        check({tag, " latency"}, 32'(lat), 32'd49);
        check({tag, " tx_count"}, 32'(ntx), 32'd2);
        check({tag, " windows"}, 32'(win), 32'd4);
        check({tag, " window_shape"}, 32'(bad), 32'd0);
        check({tag, " exclusive"}, 32'(excl), 32'd0);
        check({tag, " byte_lo"}, 32'(b0), 32'(v.res[7:0]));
        check({tag, " byte_hi"}, 32'(b1), 32'(v.res[15:8]));
        check({tag, " result"}, 32'(result), 32'(v.res));
        check({tag, " result_valid"}, 32'(result_valid), 32'd1);
    endtask

    initial begin
        int lat, ntx, win, bad, excl, k, starts;
        logic [7:0] b0, b1;

        vecs[0] = '{s0: 16'h1234, s1: 16'h1234, s2: 16'h1234, s3: 16'h1234, res: 16'h1234};
        vecs[1] = '{s0: 16'h0001, s1: 16'h0002, s2: 16'h0003, s3: 16'h0004, res: 16'h0002};
        vecs[2] = '{s0: 16'hFFFF, s1: 16'hFFFF, s2: 16'hFFFF, s3: 16'hFFFF, res: 16'hFFFF};
        vecs[3] = '{s0: 16'h0100, s1: 16'h0200, s2: 16'h0300, s3: 16'h0401, res: 16'h0280};
        vecs[4] = '{s0: 16'h8000, s1: 16'h8000, s2: 16'h8000, s3: 16'h7FFF, res: 16'h7FFF};

        rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
        load_vec(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        check("reset osc_en", 32'(osc_en), 32'd0);
        check("reset cnt_clr", 32'(cnt_clr), 32'd0);
        check("reset tx_start", 32'(tx_start), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset result_valid", 32'(result_valid), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Resend before any measurement transmits zeros.
        run_cmd(8'h52, 0, lat, ntx, win, bad, excl, b0, b1);
        check("resend_invalid latency", 32'(lat), 32'd1);
        check("resend_invalid tx_count", 32'(ntx), 32'd2);
        check("resend_invalid byte_lo", 32'(b0), 32'h00);
        check("resend_invalid byte_hi", 32'(b1), 32'h00);

        for (int i = 0; i < 5; i++) begin
            measure_and_check($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Unknown byte in IDLE is ignored.
        send_byte(8'h58);
        repeat (2) @(posedge clk);
        #1;
        check("ignore_x busy", 32'(busy), 32'd0);
        check("ignore_x cnt_clr", 32'(cnt_clr), 32'd0);

        // 'S' during GATE is ignored with no timing change.
        measure_and_check("s_in_gate", vecs[0], 5);

        run_cmd(8'h52, 0, lat, ntx, win, bad, excl, b0, b1);
        check("resend latency", 32'(lat), 32'd1);
        check("resend tx_count", 32'(ntx), 32'd2);
        check("resend byte_lo", 32'(b0), 32'h34);
        check("resend byte_hi", 32'(b1), 32'h12);
        check("resend windows", 32'(win), 32'd0);

        // Reset in GATE cycle 3 drops everything asynchronously.
        send_byte(8'h53);
        repeat (3) @(posedge clk);
        #1;
        check("gate3 osc_en_before", 32'(osc_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("gate3 osc_en", 32'(osc_en), 32'd0);
        check("gate3 busy", 32'(busy), 32'd0);
        check("gate3 result_valid", 32'(result_valid), 32'd0);
        check("gate3 result", 32'(result), 32'd0);
        check("gate3 cnt_clr", 32'(cnt_clr), 32'd0);
        check("gate3 tx_start", 32'(tx_start), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        measure_and_check("after_reset", vecs[1], 0);

        // Reset during a send: no further send strobes.
        send_byte(8'h52);
        k = 0;
        while (!tx_start && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("midsend tx_start_seen", 32'(tx_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midsend tx_start", 32'(tx_start), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        starts = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (tx_start) starts++;
        end
        check("midsend no_more_tx", 32'(starts), 32'd0);
        check("midsend busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
